determinant_calculator_param: RTL and testbench

DETERMINANT_CALCULATOR_PARAM -- requirements
Module: determinant_calculator_param

---
 rtl/determinant_calculator_param.sv | 138 +++++++++++++
 tb/tb_determinant_calculator_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/determinant_calculator_param.sv
// Sequential 2x2/3x3 signed determinant: fetches the matrix row-major from a
// combinational ROM, then accumulates one cofactor term per cycle.
// Optional feature macro: DET_SINGULAR_FLAG_EN adds the 'singular' output.
module determinant_calculator_param #(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 4,
    localparam int OUT_W  = 3*DATA_W+2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     Start,
    input  logic                     mode,
    input  logic [ADDR_W-1:0]        start_adress,
    input  logic signed [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0]        adress,
    output logic signed [OUT_W-1:0]  out_put_det,
    output logic                     Done,
    output logic                     Busy
`ifdef DET_SINGULAR_FLAG_EN
    ,
    output logic                     singular
`endif
);
    localparam int PW = 3*DATA_W;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, FINISH} state_t;

    state_t                    state;
    logic                      mode_q;
    logic [3:0]                cnt;
    logic signed [DATA_W-1:0]  elem [9];
    logic signed [OUT_W-1:0]   acc;

    logic signed [DATA_W-1:0]  op0, op1, op2;
    logic                      neg;
    logic signed [PW-1:0]      x0, x1, x2, prod;
    logic signed [OUT_W-1:0]   term, sum;
    logic                      last_load, last_term;

    // Term selection; 2x2 terms use a constant 1 as the third factor so both
    // modes share the same triple multiplier.
    always_comb begin
        op0 = elem[0];
        op1 = elem[4];
        op2 = elem[8];
        neg = 1'b0;
        if (mode_q) begin
            op2 = {{(DATA_W-1){1'b0}}, 1'b1};
            if (cnt == 4'd0) begin
                op0 = elem[0]; op1 = elem[3];
            end else begin
                op0 = elem[1]; op1 = elem[2]; neg = 1'b1;
            end
        end else begin
            case (cnt)
                4'd0:    begin op0 = elem[0]; op1 = elem[4]; op2 = elem[8]; end
                4'd1:    begin op0 = elem[1]; op1 = elem[5]; op2 = elem[6]; end
                4'd2:    begin op0 = elem[2]; op1 = elem[3]; op2 = elem[7]; end
                4'd3:    begin op0 = elem[2]; op1 = elem[4]; op2 = elem[6]; neg = 1'b1; end
                4'd4:    begin op0 = elem[1]; op1 = elem[3]; op2 = elem[8]; neg = 1'b1; end
                default: begin op0 = elem[0]; op1 = elem[5]; op2 = elem[7]; neg = 1'b1; end
            endcase
        end
    end

    always_comb begin
        x0   = {{(PW-DATA_W){op0[DATA_W-1]}}, op0};
        x1   = {{(PW-DATA_W){op1[DATA_W-1]}}, op1};
        x2   = {{(PW-DATA_W){op2[DATA_W-1]}}, op2};
        prod = x0 * x1 * x2;
        term = {{2{prod[PW-1]}}, prod};
        if (neg) term = -term;
        sum  = acc + term;
    end

    assign last_load = mode_q ? (cnt == 4'd3) : (cnt == 4'd8);
    assign last_term = mode_q ? (cnt == 4'd1) : (cnt == 4'd5);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mode_q      <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            adress      <= '0;
            out_put_det <= '0;
            Done        <= 1'b0;
            Busy        <= 1'b0;
            for (int i = 0; i < 9; i++) elem[i] <= '0;
`ifdef DET_SINGULAR_FLAG_EN
            singular    <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state  <= LOAD;
                        mode_q <= mode;
                        cnt    <= '0;
                        acc    <= '0;
                        adress <= start_adress;
                        Busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    elem[cnt] <= data_in;
                    if (last_load) begin
                        state  <= COMPUTE;
                        cnt    <= '0;
                        adress <= '0;
                    end else begin
                        cnt    <= cnt + 4'd1;
                        adress <= adress + ADDR_W'(1);
                    end
                end
                COMPUTE: begin
                    acc <= sum;
                    if (last_term) begin
                        state       <= FINISH;
                        cnt         <= '0;
                        out_put_det <= sum;
                        Done        <= 1'b1;
`ifdef DET_SINGULAR_FLAG_EN
                        singular    <= (sum == '0);
`endif
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_determinant_calculator_param.sv
// Bench for determinant_calculator_param: table of directed matrices, random
// matrices against a cofactor-expansion model, and reset / Start corner cases.
module tb_determinant_calculator_param;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int OUT_W  = 3*DATA_W+2;

    logic                     clock = 1'b0;
    logic                     reset = 1'b0;
    logic                     Start = 1'b0;
    logic                     mode  = 1'b0;
    logic [ADDR_W-1:0]        start_adress = '0;
    logic signed [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0]        adress;
    logic signed [OUT_W-1:0]  out_put_det;
    logic                     Done, Busy;
`ifdef DET_SINGULAR_FLAG_EN
    logic                     singular;
`endif

    logic signed [DATA_W-1:0] rom [16];
    assign data_in = rom[adress];

    determinant_calculator_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .Start(Start), .mode(mode),
        .start_adress(start_adress), .data_in(data_in), .adress(adress),
        .out_put_det(out_put_det), .Done(Done), .Busy(Busy)
`ifdef DET_SINGULAR_FLAG_EN
        , .singular(singular)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       mode;
        logic [3:0] sa;
        int         el [9];
        int         exp;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: Laplace expansion along the first row
    function automatic int det_model(input logic m, input int e [9]);
        if (m) return e[0]*e[3] - e[1]*e[2];
        return e[0]*(e[4]*e[8] - e[5]*e[7])
             - e[1]*(e[3]*e[8] - e[5]*e[6])
             + e[2]*(e[3]*e[7] - e[4]*e[6]);
    endfunction

    task automatic kick(input logic m, input logic [3:0] sa);
        @(negedge clock);
        Start = 1'b1; mode = m; start_adress = sa;
        @(posedge clock);
        #1 Start = 1'b0;
    endtask

    // Returns at the negedge inside the FINISH cycle (or after the bound).
    task automatic run_vec(input vec_t v, input int repulse_at, input bit prestarted);
        int nn, want_edges, c;
        bit seen;
        logic [3:0] a;
        nn = v.mode ? 4 : 9;
        want_edges = v.mode ? 6 : 15;
        for (int k = 0; k < nn; k++) begin
            a = v.sa + 4'(k);
            rom[a] = 8'(v.el[k]);
        end
        if (!prestarted) kick(v.mode, v.sa);
        c = 0; seen = 1'b0;
        while (c <= 40) begin
            @(negedge clock);
            if (c < nn) chk("adress_seq", adress, 4'(v.sa + 4'(c)));
            if (Done) begin seen = 1'b1; break; end
            if (c == repulse_at) begin
                Start = 1'b1; mode = ~v.mode; start_adress = v.sa + 4'd5;
            end
            @(posedge clock);
            #1 Start = 1'b0;
            c++;
        end
        if (!seen) chk("done_timeout", 0, 1);
        chk("done_latency", c, want_edges);
        chk("det", $signed(out_put_det), v.exp);
`ifdef DET_SINGULAR_FLAG_EN
        chk("singular", singular, (v.exp == 0));
`endif
    endtask

    task automatic idle_check(input int exp);
        @(posedge clock);
        @(negedge clock);
        chk("done_pulse_end", Done, 0);
        chk("busy_idle", Busy, 0);
        chk("adress_idle", adress, 0);
        chk("det_hold", $signed(out_put_det), exp);
    endtask

    task automatic reset_check();
        chk("rst_det", out_put_det, 0);
        chk("rst_done", Done, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_adress", adress, 0);
`ifdef DET_SINGULAR_FLAG_EN
        chk("rst_singular", singular, 0);
`endif
    endtask

    vec_t tbl [6];
    vec_t rv;

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);

        tbl[0].mode = 1'b0; tbl[0].sa = 4'd0;  tbl[0].el = '{1,0,0,0,1,0,0,0,1};            tbl[0].exp = 1;
        tbl[1].mode = 1'b1; tbl[1].sa = 4'd1;  tbl[1].el = '{3,1,2,4,0,0,0,0,0};            tbl[1].exp = 10;
        tbl[2].mode = 1'b0; tbl[2].sa = 4'd0;  tbl[2].el = '{-1,0,0,0,2,0,0,0,3};           tbl[2].exp = -6;
        tbl[3].mode = 1'b0; tbl[3].sa = 4'd14; tbl[3].el = '{1,2,3,4,5,6,7,8,9};            tbl[3].exp = 0;
        tbl[4].mode = 1'b0; tbl[4].sa = 4'd9;  tbl[4].el = '{-128,0,0,0,-128,0,0,0,-128};   tbl[4].exp = -2097152;
        tbl[5].mode = 1'b1; tbl[5].sa = 4'd15; tbl[5].el = '{-128,127,-128,-128,0,0,0,0,0}; tbl[5].exp = 32640;

        #1 reset_check();
        repeat (2) @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i], -1, 1'b0);
            idle_check(tbl[i].exp);
        end

        // Start re-pulsed mid-LOAD must not disturb the running operation
        run_vec(tbl[0], 3, 1'b0);
        idle_check(tbl[0].exp);

        // Start in FINISH ignored, held into the following IDLE cycle accepted
        run_vec(tbl[2], -1, 1'b0);
        Start = 1'b1; mode = tbl[1].mode; start_adress = tbl[1].sa;
        @(posedge clock);
        @(negedge clock);
        chk("finish_start_ignored_busy", Busy, 0);
        chk("finish_start_ignored_adr", adress, 0);
        @(posedge clock);
        #1 Start = 1'b0;
        run_vec(tbl[1], -1, 1'b1);
        idle_check(tbl[1].exp);

        // Reset mid-COMPUTE: outputs clear immediately, no Done while held
        kick(1'b0, 4'd3);
        repeat (11) @(negedge clock);
        reset = 1'b0;
        #1 reset_check();
        repeat (20) begin
            @(negedge clock);
            if (Done) chk("done_during_reset", Done, 0);
        end
        reset = 1'b1;
        run_vec(tbl[4], -1, 1'b0);
        idle_check(tbl[4].exp);

        // Reset mid-LOAD with a nonzero address on the bus
        kick(1'b0, 4'd5);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1 reset_check();
        @(negedge clock);
        reset = 1'b1;

        for (int n = 0; n < 24; n++) begin
            rv.mode = 1'($urandom_range(0, 1));
            rv.sa   = 4'($urandom);
            for (int k = 0; k < 9; k++) rv.el[k] = $signed(8'($urandom));
            if (n == 5) for (int k = 0; k < 9; k++) rv.el[k] = -128;
            rv.exp  = det_model(rv.mode, rv.el);
            run_vec(rv, -1, 1'b0);
            idle_check(rv.exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
